// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Brief    : Shared constants, FIFO word layout and FSM state type for the
//            Ethernet/UDP TLP extractor.
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int HDR_BYTES      = 42;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    // FIFO read word: {tkeep[7:0], tdata[63:0], tuser[7:0], tlast}
    localparam int FIFO_W         = 81;
    localparam int FIFO_LAST_BIT  = 0;
    localparam int FIFO_USER_LSB  = 1;
    localparam int FIFO_DATA_LSB  = 9;
    localparam int FIFO_KEEP_LSB  = 73;

    // The header ends mid-word, so the payload is realigned by this many bytes
    localparam int SHIFT_BYTES    = HDR_BYTES % 8;
    localparam int TAIL_BYTES     = 8 - SHIFT_BYTES;

    localparam logic [2:0] ETYPE_IDX    = 3'd1;
    localparam logic [2:0] HDR_LAST_IDX = 3'(HDR_BYTES / 8 - 1);
    localparam logic [2:0] PAYLOAD_IDX  = 3'(HDR_BYTES / 8);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    // Network-order 16-bit field from two little-endian byte lanes
    function automatic logic [15:0] swap16(input logic [15:0] le);
        return {le[7:0], le[15:8]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_keep_shift.sv
`default_nettype none
// ============================================================================
// Module   : eth_keep_shift
// Brief    : Combinational realign joining the tail of one word with the head
//            bytes of the next, for both data and byte-keep.
// Revision : 1.0 - initial release
// ============================================================================
module eth_keep_shift
    import eth_pkg::*;
(
    input  logic [TAIL_BYTES*8-1:0]  tail_data,
    input  logic [TAIL_BYTES-1:0]    tail_keep,
    input  logic [SHIFT_BYTES*8-1:0] head_data,
    input  logic [SHIFT_BYTES-1:0]   head_keep,
    output logic [63:0]              data,
    output logic [7:0]               keep
);

    assign data = {head_data, tail_data};
    assign keep = {head_keep, tail_keep};

endmodule
`default_nettype wire

// File: rtl/eth_tlp_extract.sv
`default_nettype none
// ============================================================================
// Module   : eth_tlp_extract
// Brief    : Validates Eth/IPv4/UDP headers of FIFO frames and streams the
//            2-byte-realigned TLP payload out on AXI-Stream.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tlp_extract
    import eth_pkg::*;
#(
    parameter int          C_DATA_WIDTH = 64,
    parameter logic [15:0] UDP_PORT     = 16'h3000
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [FIFO_W-1:0]         dout,
    input  logic                      empty,
    output logic                      rd_en,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [21:0]               m_axis_tuser,
    output logic [31:0]               frames_ok,
    output logic [31:0]               frames_drop
);

    state_t                  r_state;
    logic [2:0]              r_idx;
    logic [TAIL_BYTES*8-1:0] r_tail_data;
    logic [TAIL_BYTES-1:0]   r_tail_keep;
    logic                    r_tvalid;
    logic                    r_tlast;
    logic [63:0]             r_tdata;
    logic [7:0]              r_tkeep;
    logic [31:0]             r_frames_ok;
    logic [31:0]             r_frames_drop;

    logic [63:0]             w_in_data;
    logic [7:0]              w_in_keep;
    logic                    w_in_last;
    logic                    w_out_free;
    logic                    w_first;
    logic                    w_more;
    logic                    w_no_head;
    logic                    w_rd_en;
    logic                    w_emit;
    logic                    w_emit_last;
    logic                    w_drop_done;
    logic                    w_hdr_bad;
    logic [TAIL_BYTES*8-1:0] w_sh_tail_data;
    logic [TAIL_BYTES-1:0]   w_sh_tail_keep;
    logic [SHIFT_BYTES*8-1:0] w_sh_head_data;
    logic [SHIFT_BYTES-1:0]  w_sh_head_keep;
    logic [63:0]             w_sh_data;
    logic [7:0]              w_sh_keep;
    logic                    w_unused;

    assign w_in_data  = dout[FIFO_DATA_LSB +: 64];
    assign w_in_keep  = dout[FIFO_KEEP_LSB +: 8];
    assign w_in_last  = dout[FIFO_LAST_BIT];
    assign w_unused   = ^dout[FIFO_USER_LSB +: 8];

    assign w_out_free = !r_tvalid || m_axis_tready;
    assign w_first    = (r_idx == PAYLOAD_IDX);
    // A last word still holds bytes past its head lanes, so a tail remains
    assign w_more     = w_in_keep[SHIFT_BYTES];
    assign w_hdr_bad  = ((r_idx == ETYPE_IDX)    && (swap16(w_in_data[47:32]) != ETHERTYPE_IPV4)) ||
                        ((r_idx == HDR_LAST_IDX) && (swap16(w_in_data[47:32]) != UDP_PORT));

    // First payload word or flush: the current tail stands alone
    assign w_no_head      = (r_state == ST_FLUSH) || w_first;
    assign w_sh_tail_data = w_first ? w_in_data[63:SHIFT_BYTES*8] : r_tail_data;
    assign w_sh_tail_keep = w_first ? w_in_keep[7:SHIFT_BYTES]    : r_tail_keep;
    assign w_sh_head_data = w_no_head ? '0 : w_in_data[SHIFT_BYTES*8-1:0];
    assign w_sh_head_keep = w_no_head ? '0 : w_in_keep[SHIFT_BYTES-1:0];

    eth_keep_shift u_keep_shift (
        .tail_data (w_sh_tail_data),
        .tail_keep (w_sh_tail_keep),
        .head_data (w_sh_head_data),
        .head_keep (w_sh_head_keep),
        .data      (w_sh_data),
        .keep      (w_sh_keep)
    );

    always_comb begin
        w_rd_en     = 1'b0;
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        w_drop_done = 1'b0;
        case (r_state)
            ST_HDR, ST_DROP: begin
                w_rd_en     = !empty;
                w_drop_done = !empty && w_in_last;
            end
            ST_PAYLOAD: begin
                w_rd_en = !empty && w_out_free;
                if (w_rd_en) begin
                    if (w_first) begin
                        w_emit      = w_in_last && w_more;
                        w_emit_last = 1'b1;
                        w_drop_done = w_in_last && !w_more;
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_last = w_in_last && !w_more;
                    end
                end
            end
            ST_FLUSH: begin
                w_emit      = w_out_free;
                w_emit_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_tail_data   <= '0;
            r_tail_keep   <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_frames_ok   <= '0;
            r_frames_drop <= '0;
        end else begin
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
                if (r_tlast) begin
                    r_frames_ok <= sat_inc(r_frames_ok);
                end
            end
            if (w_emit) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_sh_data;
                r_tkeep  <= w_sh_keep;
                r_tlast  <= w_emit_last;
            end
            if (w_drop_done) begin
                r_frames_drop <= sat_inc(r_frames_drop);
            end

            case (r_state)
                ST_IDLE: begin
                    r_idx   <= 3'd0;
                    r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (w_rd_en) begin
                        if (w_in_last) begin
                            r_state <= ST_IDLE;
                        end else if (w_hdr_bad) begin
                            r_state <= ST_DROP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            if (r_idx == HDR_LAST_IDX) begin
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_rd_en) begin
                        r_tail_data <= w_in_data[63:SHIFT_BYTES*8];
                        r_tail_keep <= w_in_keep[7:SHIFT_BYTES];
                        if (w_first) begin
                            r_idx <= r_idx + 3'd1;
                        end
                        if (w_in_last) begin
                            r_state <= (!w_first && w_more) ? ST_FLUSH : ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_out_free) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (w_rd_en && w_in_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_en         = w_rd_en;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = '0;
    assign frames_ok     = r_frames_ok;
    assign frames_drop   = r_frames_drop;

endmodule
`default_nettype wire

// File: tb/tb_eth_tlp_extract.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tlp_extract
// Brief    : Self-checking bench: FWFT FIFO model feeding frames, byte-level
//            reference model of the extracted payload beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tlp_extract;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        user_reset;
    logic [80:0] dout;
    logic        empty;
    logic        rd_en;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [21:0] m_axis_tuser;
    logic [31:0] frames_ok;
    logic [31:0] frames_drop;

    logic [80:0] mem [4096];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    beat_t       rxq[$];
    beat_t       expq[$];
    int          exp_ok = 0;
    int          exp_drop = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_err = 0;
    int          empty_err = 0;
    bit          stall_chk = 1'b0;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    assign dout  = mem[rd_ptr[11:0]];
    assign empty = (wr_ptr == rd_ptr);

    eth_tlp_extract #(
        .C_DATA_WIDTH (64),
        .UDP_PORT     (16'h3000)
    ) dut (
        .user_clk      (clk),
        .user_reset    (user_reset),
        .dout          (dout),
        .empty         (empty),
        .rd_en         (rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .frames_ok     (frames_ok),
        .frames_drop   (frames_drop)
    );

    always @(posedge clk) begin
        if (rd_en && !empty) rd_ptr <= rd_ptr + 1;
    end

    // Beats seen valid+ready here complete on the following rising edge
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready)
            rxq.push_back(beat_t'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}));
        if (stall_chk && m_axis_tvalid && !m_axis_tready && rd_en)
            stall_err <= stall_err + 1;
        if (rd_en && empty)
            empty_err <= empty_err + 1;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m;
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
        return m;
    endfunction

    // Pushes a frame into the FIFO and appends the expected result to the model
    task automatic push_frame(input int len, input logic [15:0] et, input logic [15:0] port);
        logic [7:0] fb [256];
        int nw;
        nw = (len + 7) / 8;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        fb[12] = et[15:8];   fb[13] = et[7:0];
        fb[36] = port[15:8]; fb[37] = port[7:0];
        for (int w = 0; w < nw; w++) begin
            logic [63:0] d;
            logic [7:0]  k;
            for (int b = 0; b < 8; b++) begin
                d[8*b +: 8] = fb[8*w+b];
                k[b] = (8*w + b < len);
            end
            mem[wr_ptr[11:0]] = {k, d, 8'($urandom), (w == nw - 1)};
            wr_ptr++;
        end
        if (len > 42 && et == 16'h0800 && port == 16'h3000) begin
            int m;
            m = len - 42;
            for (int k = 0; 8*k < m; k++) begin
                beat_t e;
                e = '0;
                for (int j = 0; j < 8; j++) begin
                    if (8*k + j < m) begin
                        e.data[8*j +: 8] = fb[42 + 8*k + j];
                        e.keep[j] = 1'b1;
                    end
                end
                e.last = (8*k + 8 >= m);
                expq.push_back(e);
            end
            exp_ok++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic wait_done(output bit timeout);
        int cyc;
        cyc = 0;
        timeout = 1'b0;
        while (!(frames_ok == 32'(exp_ok) && frames_drop == 32'(exp_drop) &&
                 wr_ptr == rd_ptr && !m_axis_tvalid)) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 3000) begin
                timeout = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++; if (m_axis_tdata !== 64'd0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_checks++; if (m_axis_tkeep !== 8'd0) begin n_fail++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep); end
        n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        n_checks++; if (m_axis_tuser !== 22'd0) begin n_fail++; $display("FAIL reset_tuser: got %h want 0", m_axis_tuser); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_checks++; if (frames_ok !== 32'd0) begin n_fail++; $display("FAIL reset_frames_ok: got %0d want 0", frames_ok); end
        n_checks++; if (frames_drop !== 32'd0) begin n_fail++; $display("FAIL reset_frames_drop: got %0d want 0", frames_drop); end
    endtask

    task automatic test_single_frame(input string name, input int len, input logic [15:0] et, input logic [15:0] port);
        bit to;
        rxq.delete();
        expq.delete();
        push_frame(len, et, port);
        wait_done(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL %s_timeout: frame not finished, got ok=%0d drop=%0d want ok=%0d drop=%0d", name, frames_ok, frames_drop, exp_ok, exp_drop); end
        n_checks++; if (rxq.size() != expq.size()) begin n_fail++; $display("FAIL %s_beats: got %0d beats want %0d", name, rxq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            n_checks++;
            if (((rxq[i].data & kmask(expq[i].keep)) !== expq[i].data) || rxq[i].keep !== expq[i].keep || rxq[i].last !== expq[i].last) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got data=%h keep=%h last=%b want data=%h keep=%h last=%b", name, i,
                         rxq[i].data, rxq[i].keep, rxq[i].last, expq[i].data, expq[i].keep, expq[i].last);
            end
        end
        n_checks++; if (frames_ok !== 32'(exp_ok)) begin n_fail++; $display("FAIL %s_frames_ok: got %0d want %0d", name, frames_ok, exp_ok); end
        n_checks++; if (frames_drop !== 32'(exp_drop)) begin n_fail++; $display("FAIL %s_frames_drop: got %0d want %0d", name, frames_drop, exp_drop); end
    endtask

    task automatic test_drops();
        bit to;
        rxq.delete();
        expq.delete();
        push_frame(70, 16'h0800, 16'h1234);
        wait_done(to);
        n_checks++; if (to || rxq.size() != 0) begin n_fail++; $display("FAIL drop_port_out: got %0d beats timeout=%b want 0 beats", rxq.size(), to); end
        n_checks++; if (frames_drop !== 32'(exp_drop)) begin n_fail++; $display("FAIL drop_port_count: got %0d want %0d", frames_drop, exp_drop); end
        push_frame(70, 16'h86DD, 16'h3000);
        wait_done(to);
        n_checks++; if (to || rxq.size() != 0) begin n_fail++; $display("FAIL drop_etype_out: got %0d beats timeout=%b want 0 beats", rxq.size(), to); end
        n_checks++; if (frames_drop !== 32'(exp_drop)) begin n_fail++; $display("FAIL drop_etype_count: got %0d want %0d", frames_drop, exp_drop); end
        test_single_frame("after_drop", 58, 16'h0800, 16'h3000);
    endtask

    task automatic test_backpressure();
        rdy_mode  = 1;
        stall_chk = 1'b1;
        test_single_frame("bp", 42 + 64, 16'h0800, 16'h3000);
        stall_chk = 1'b0;
        rdy_mode  = 0;
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_rd_en_stall: got %0d pops while stalled want 0", stall_err); end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        rxq.delete();
        expq.delete();
        rdy_mode = 0;
        push_frame(42 + 64, 16'h0800, 16'h3000);
        cyc = 0;
        while (!(rxq.size() == 2 && m_axis_tvalid) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL rst_mid_reach_beat3: got %0d beats want 2 plus a valid third", rxq.size()); end
        user_reset = 1'b1;
        #1;
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++; if (m_axis_tdata !== 64'd0 || m_axis_tkeep !== 8'd0 || m_axis_tlast !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got data=%h keep=%h last=%b want all 0", m_axis_tdata, m_axis_tkeep, m_axis_tlast); end
        n_checks++; if (frames_ok !== 32'd0 || frames_drop !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_counters: got ok=%0d drop=%0d want 0/0", frames_ok, frames_drop); end
        wr_ptr = rd_ptr;
        exp_ok = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        user_reset = 1'b0;
        test_single_frame("after_reset", 62, 16'h0800, 16'h3000);
    endtask

    task automatic test_back_to_back();
        bit to;
        rxq.delete();
        expq.delete();
        rdy_mode = 0;
        push_frame(58, 16'h0800, 16'h3000);
        push_frame(30, 16'h0800, 16'h3000);
        push_frame(54, 16'h0800, 16'h3000);
        push_frame(43, 16'h0800, 16'h3000);
        push_frame(42, 16'h0800, 16'h3000);
        push_frame(62, 16'h0800, 16'h3000);
        wait_done(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got ok=%0d drop=%0d want ok=%0d drop=%0d", frames_ok, frames_drop, exp_ok, exp_drop); end
        n_checks++; if (rxq.size() != expq.size()) begin n_fail++; $display("FAIL b2b_beats: got %0d want %0d", rxq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            n_checks++;
            if (((rxq[i].data & kmask(expq[i].keep)) !== expq[i].data) || rxq[i].keep !== expq[i].keep || rxq[i].last !== expq[i].last) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got data=%h keep=%h last=%b want data=%h keep=%h last=%b", i,
                         rxq[i].data, rxq[i].keep, rxq[i].last, expq[i].data, expq[i].keep, expq[i].last);
            end
        end
        n_checks++; if (frames_ok !== 32'(exp_ok) || frames_drop !== 32'(exp_drop)) begin
            n_fail++; $display("FAIL b2b_counters: got ok=%0d drop=%0d want ok=%0d drop=%0d", frames_ok, frames_drop, exp_ok, exp_drop); end
    endtask

    task automatic test_random();
        bit to;
        rdy_mode = 2;
        for (int batch = 0; batch < 6; batch++) begin
            rxq.delete();
            expq.delete();
            for (int f = 0; f < 5; f++) begin
                int          len;
                int          sel;
                logic [15:0] et;
                logic [15:0] port;
                len  = $urandom_range(20, 120);
                sel  = $urandom_range(0, 5);
                et   = (sel == 0) ? 16'h86DD : 16'h0800;
                port = 16'h3000;
                if (sel == 1) begin
                    port = 16'($urandom);
                    if (port == 16'h3000) port = 16'h1234;
                end
                push_frame(len, et, port);
            end
            wait_done(to);
            n_checks++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: got ok=%0d drop=%0d want ok=%0d drop=%0d", batch, frames_ok, frames_drop, exp_ok, exp_drop); end
            n_checks++; if (rxq.size() != expq.size()) begin n_fail++; $display("FAIL rnd%0d_beats: got %0d want %0d", batch, rxq.size(), expq.size()); end
            for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
                n_checks++;
                if (((rxq[i].data & kmask(expq[i].keep)) !== expq[i].data) || rxq[i].keep !== expq[i].keep || rxq[i].last !== expq[i].last) begin
                    n_fail++;
                    $display("FAIL rnd%0d_beat%0d: got data=%h keep=%h last=%b want data=%h keep=%h last=%b", batch, i,
                             rxq[i].data, rxq[i].keep, rxq[i].last, expq[i].data, expq[i].keep, expq[i].last);
                end
            end
            n_checks++; if (frames_ok !== 32'(exp_ok) || frames_drop !== 32'(exp_drop)) begin
                n_fail++; $display("FAIL rnd%0d_counters: got ok=%0d drop=%0d want ok=%0d drop=%0d", batch, frames_ok, frames_drop, exp_ok, exp_drop); end
        end
        rdy_mode = 0;
    endtask

    initial begin
        user_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        user_reset = 1'b0;
        @(posedge clk); #1;
        test_single_frame("f58", 58, 16'h0800, 16'h3000);
        test_single_frame("f62", 62, 16'h0800, 16'h3000);
        test_single_frame("f54", 54, 16'h0800, 16'h3000);
        test_drops();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        n_checks++; if (empty_err != 0) begin n_fail++; $display("FAIL rd_en_when_empty: got %0d pops of an empty FIFO want 0", empty_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_tlp_extract.md
ETH_TLP_EXTRACT -- requirements
Module: eth_tlp_extract

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, meaning the output stream data width; only 64 is supported.
REQ-002 SHALL have parameter UDP_PORT, default 16'h3000, meaning the UDP destination port that carries TLPs.
REQ-003 SHALL have port user_clk  input  1  the single clock for all logic.
REQ-004 SHALL have port user_reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port dout  input  81  FIFO read word: [80:73] tkeep (byte mask), [72:9] tdata, [8:1] tuser, [0] tlast.
REQ-006 SHALL have port empty  input  1  FIFO empty; the FIFO is first-word-fall-through, so dout is valid whenever empty=0.
REQ-007 SHALL have port rd_en  output  1  FIFO pop strobe.
REQ-008 SHALL have port m_axis_tdata  output  64  extracted TLP data, byte 0 in [7:0].
REQ-009 SHALL have port m_axis_tkeep  output  8  byte-valid mask, contiguous from lane 0.
REQ-010 SHALL have port m_axis_tlast, m_axis_tvalid  output  1 each, plus m_axis_tready  input  1.
REQ-011 SHALL have port m_axis_tuser  output  22  tied to 0.
REQ-012 SHALL have ports frames_ok, frames_drop  output  32 each  saturating frame counters.

Function
REQ-013 SHALL treat each FIFO frame as 42 header bytes (Eth 14, IP 20, UDP 8) followed by the TLP payload.
REQ-014 SHALL assert rd_en only when empty=0 and the state can consume the word (output register free, or m_axis_tready=1, or state is HDR or DROP).
REQ-015 SHALL implement the states IDLE, HDR, PAYLOAD, FLUSH and DROP, tracked by a 3-bit word index within the frame.
REQ-016 SHALL, in HDR, pop words 0-4 and check that ethertype equals 16'h0800, where the ethertype is {word1[39:32], word1[47:40]}.
REQ-017 SHALL, in HDR, check that the UDP destination port {word4[39:32], word4[47:40]} equals UDP_PORT.
REQ-018 SHALL go to DROP on any check failure and pop words until tlast.
REQ-019 SHALL realign the payload by 2 bytes: output word k = {in[6+k][15:0], in[5+k][63:16]}, with keep derived the same way.
REQ-020 SHALL handle an input last word with n valid bytes as follows: if n<=2, the combined word is final (tlast) with keep for 6+n bytes; if n>2, emit the combined word, then in FLUSH emit one word holding n-2 bytes with tlast.
REQ-021 SHALL, when word 5 itself is last, emit n-2 payload bytes as a single tlast word if n>2; otherwise drop the frame.
REQ-022 SHALL drop any frame with tlast before word 5, with no output beat.
REQ-023 SHALL hold m_axis_* stable while tvalid=1 and tready=0; a transfer completes on tvalid and tready both high.
REQ-024 SHALL have a latency of 1 cycle from the pop of word 6+k to m_axis_tvalid for output word k.
REQ-025 SHALL increment frames_ok on an emitted tlast beat and frames_drop on the final pop of a dropped frame; both counters saturate at 32'hFFFFFFFF.

Reset
REQ-026 SHALL, on user_reset, go to IDLE, clear the index and the realign register, and drive rd_en=0, m_axis_tvalid=0, tdata/tkeep/tlast=0 and both counters to 0.
REQ-027 SHALL, when reset occurs mid-frame, discard the partial frame; the FIFO contents are not flushed.

Structure
REQ-028 SHALL take HDR_BYTES=42, ETHERTYPE_IPV4=16'h0800 and the FIFO field offsets from the shared package eth_pkg, alongside a state enum typedef.
REQ-029 SHALL contain one sub-module, eth_keep_shift, which is the combinational 2-byte realign of data and keep.

Verification
REQ-030 SHALL cover a 58-byte frame with port 0x3000 -> 16 payload bytes out as 2 beats, keep FF/FF, tlast on beat 2, frames_ok=1.
REQ-031 SHALL cover a 62-byte frame (last keep 0F) -> 3 beats, keep FF/FF/0F.
REQ-032 SHALL cover a 54-byte frame (last keep 0F) -> 2 beats with keep FF/0F, exercising the FLUSH path.
REQ-033 SHALL cover a frame with UDP port 0x1234, and separately a frame with ethertype 0x86DD -> no output, frames_drop increments by one each, and the next valid frame passes unaffected.
REQ-034 SHALL cover m_axis_tready toggling 1010 across a 64-byte-payload frame -> data intact and rd_en never asserted while the output is stalled and full.
REQ-035 SHALL cover user_reset asserted during beat 3 of a frame -> outputs zero immediately; after release the next frame is extracted correctly.
